// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state encoding and shared widths for the PLL reset sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_seq_state_t;

  localparam int LOSSCNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with synchronous active-high clear
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock supervisor driving the downstream system reset
// PLL_SEQ_LOSSCNT_EN adds the saturating lock_loss_cnt output and its counter.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY        = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state_o
`ifdef PLL_SEQ_LOSSCNT_EN
  ,
  output logic [LOSSCNT_W-1:0] lock_loss_cnt
`endif
);

  localparam int CNT_W   = $clog2(max3(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC)) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  pll_seq_state_t       state_q;
  pll_seq_state_t       state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 cnt_clr;
  logic [RETRY_W-1:0]   retry_q;
  logic [RETRY_W-1:0]   retry_d;
  logic [RETRY_W-1:0]   retry_inc;
  logic                 locked_s;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (pll_locked),
    .q  (locked_s)
  );

  assign retry_inc = retry_q + RETRY_W'(1);

  // One shared counter: restarts on every state change and on a relock during the pulse.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if (cnt_clr || (state_d != state_q) || (state_q == RUN) || (state_q == FAULT)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    retry_d = retry_q;
    case (state_q)
      RESET_PLL: begin
        if (relock_req) begin
          cnt_clr = 1'b1;
        end else if (cnt_q == PULSE_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (relock_req) begin
          state_d = RESET_PLL;
        end else if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (relock_req) begin
          state_d = RESET_PLL;
        end else if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (relock_req || !locked_s) begin
          state_d = RESET_PLL;
        end
      end
      FAULT: begin
        if (relock_req) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase
  end

  always_comb begin
    pll_rst = 1'b0;
    sys_rst = 1'b1;
    ready   = 1'b0;
    fault   = 1'b0;
    case (state_q)
      RESET_PLL: pll_rst = 1'b1;
      RUN: begin
        sys_rst = 1'b0;
        ready   = 1'b1;
      end
      FAULT:     fault = 1'b1;
      default: begin
      end
    endcase
  end

  assign state_o = state_q;

`ifdef PLL_SEQ_LOSSCNT_EN
  logic loss_hit;

  // A loss coinciding with relock_req is still a loss.
  assign loss_hit = (state_q == RUN) && !locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_cnt <= '0;
    end else if (loss_hit && (lock_loss_cnt != {LOSSCNT_W{1'b1}})) begin
      lock_loss_cnt <= lock_loss_cnt + LOSSCNT_W'(1);
    end
  end
`endif

endmodule
